// File: rtl/fpga_cfg_loader.sv
// ---------------------------------------------------------------------------
// fpga_cfg_loader
//
// Word-serial configuration loader for fpga_top. A checksummed image arrives
// over a valid/ready stream and is assembled into a shadow register. Only
// when every data word has arrived and the XOR checksum matches is the
// whole shadow image copied to the fabric select buses, in a single edge.
// The fabric never sees a partial image, and a failed load keeps the
// previous configuration in place.
//
// Parameters:
//   DW        stream word width (1, 2, 4, 8, 16 or 32)
//   CFG_BITS  total configuration bits, 900+1728+80+4*30 = 2828 (fixed)
//   WORDS     data words per image, ceil(CFG_BITS/DW) (derived)
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   start           one-cycle pulse that begins a load (ignored while loading)
//   cfg_data        stream word
//   cfg_valid       cfg_data is valid
//   cfg_ready       loader accepts a word this cycle (high in LOAD)
//   cfg_busy        high in LOAD
//   cfg_done        last load committed successfully
//   cfg_error       last load failed its checksum
//   brbselect       900-bit fabric configuration
//   bsbselect       1728-bit fabric configuration
//   lbselect        80-bit fabric configuration
//   *ioselect       30-bit IO configuration, one bus per side
// ---------------------------------------------------------------------------
module fpga_cfg_loader #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] cfg_data,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  output logic          cfg_busy,
  output logic          cfg_done,
  output logic          cfg_error,
  output logic [899:0]  brbselect,
  output logic [1727:0] bsbselect,
  output logic [79:0]   lbselect,
  output logic [29:0]   leftioselect,
  output logic [29:0]   rightioselect,
  output logic [29:0]   topioselect,
  output logic [29:0]   bottomioselect
);

  localparam int CFG_BITS = 2828;
  localparam int WORDS    = (CFG_BITS + DW - 1) / DW;
  // Counter holds 0..WORDS; the value WORDS marks the checksum transfer.
  localparam int CW       = $clog2(WORDS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE,
    S_ERROR
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [DW-1:0]       r_xor;
  logic [CFG_BITS-1:0] r_shadow;
  logic [CFG_BITS-1:0] w_shadowNext;
  logic                w_xfer;
  logic                w_lastXfer;

  assign w_xfer     = cfg_valid && cfg_ready;
  assign w_lastXfer = (r_cnt == CW'(WORDS));

  // Each shadow bit g belongs to word g/DW, lane g%DW. Padding lanes of the
  // last word have no shadow bit, so they are dropped here but still reach
  // the running XOR.
  for (genvar g = 0; g < CFG_BITS; g++) begin : g_map
    assign w_shadowNext[g] = (r_cnt == CW'(g / DW)) ? cfg_data[g % DW] : r_shadow[g];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_xor          <= '0;
      r_shadow       <= '0;
      cfg_ready      <= 1'b0;
      cfg_busy       <= 1'b0;
      cfg_done       <= 1'b0;
      cfg_error      <= 1'b0;
      brbselect      <= '0;
      bsbselect      <= '0;
      lbselect       <= '0;
      leftioselect   <= '0;
      rightioselect  <= '0;
      topioselect    <= '0;
      bottomioselect <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_xfer) begin
            if (w_lastXfer) begin
              // Checksum word: ready drops on this same edge so nothing more
              // is taken; the commit happens only on a checksum match.
              cfg_ready <= 1'b0;
              cfg_busy  <= 1'b0;
              if (cfg_data == r_xor) begin
                r_state        <= S_DONE;
                cfg_done       <= 1'b1;
                brbselect      <= r_shadow[899:0];
                bsbselect      <= r_shadow[2627:900];
                lbselect       <= r_shadow[2707:2628];
                leftioselect   <= r_shadow[2737:2708];
                rightioselect  <= r_shadow[2767:2738];
                topioselect    <= r_shadow[2797:2768];
                bottomioselect <= r_shadow[2827:2798];
              end else begin
                r_state   <= S_ERROR;
                cfg_error <= 1'b1;
              end
            end else begin
              r_shadow <= w_shadowNext;
              r_xor    <= r_xor ^ cfg_data;
              r_cnt    <= r_cnt + CW'(1);
            end
          end
        end
        default: begin
          // IDLE, DONE and ERROR all restart identically on start.
          if (start) begin
            r_state   <= S_LOAD;
            r_cnt     <= '0;
            r_xor     <= '0;
            r_shadow  <= '0;
            cfg_ready <= 1'b1;
            cfg_busy  <= 1'b1;
            cfg_done  <= 1'b0;
            cfg_error <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/fpga_cfg_loader.md
# fpga_cfg_loader

Word-serial configuration loader for `fpga_top`. It receives a checksummed configuration stream over a valid/ready interface and assembles it into shadow registers. Once the stream is complete and the checksum passes, it commits the whole image in one cycle to the fabric select buses: `brbselect`, `bsbselect`, `lbselect` and the four IO selects. The fabric therefore never sees a partially written configuration, and a failed load leaves the previous configuration active.

## Interface
Parameters:
- `DW`, 16: stream word width; legal values 1, 2, 4, 8, 16, 32.
- `CFG_BITS`, 2828: total configuration bits (900+1728+80+4×30); fixed.
- `WORDS`, ceil(CFG_BITS/DW): data words per image; 177 at DW=16.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a load.
- `cfg_data` in DW: stream word.
- `cfg_valid` in 1: `cfg_data` is valid.
- `cfg_ready` out 1: loader accepts a word this cycle.
- `cfg_busy` out 1: high in LOAD.
- `cfg_done` out 1: last load committed successfully.
- `cfg_error` out 1: last load failed its checksum.
- `brbselect` out 900, `bsbselect` out 1728, `lbselect` out 80: fabric configuration.
- `leftioselect`, `rightioselect`, `topioselect`, `bottomioselect` out 30 each: IO configuration.

## Operation
- FSM states: IDLE, LOAD, DONE, ERROR. Reset state is IDLE.
- From IDLE, DONE or ERROR, `start`=1 moves to LOAD. Entering LOAD clears the word counter, the running XOR and all shadow bits.
- In LOAD:
  - `cfg_ready`=1 and `cfg_busy`=1.
  - A transfer occurs on a cycle with `cfg_valid`&&`cfg_ready`. No transfer means nothing changes.
  - Transfers 0..WORDS-1 are data words. Word k bit j maps to global bit g = k·DW+j.
  - Transfer WORDS is the checksum word.
- Global bit map:
  - g 0–899: `brbselect`[g].
  - 900–2627: `bsbselect`[g−900].
  - 2628–2707: `lbselect`[g−2628].
  - 2708–2737: `leftioselect`.
  - 2738–2767: `rightioselect`.
  - 2768–2797: `topioselect`.
  - 2798–2827: `bottomioselect`.
  - g ≥ 2828 is padding: dropped, but still included in the XOR.
- Checksum: the XOR of all WORDS data words must equal the checksum word.
  - On a match, all shadow bits are copied to the outputs in the same edge, and the FSM goes to DONE.
  - On a mismatch, the outputs are unchanged and the FSM goes to ERROR.
- `start` asserted while in LOAD is ignored.
- `cfg_done` is high only in DONE and `cfg_error` only in ERROR. Both clear when LOAD is entered.
- The output configuration changes only on a successful commit or on reset.
- The word counter is wide enough for WORDS+1 values and never wraps within a load.

## Timing
- Reset values: every select output 0; `cfg_ready`, `cfg_busy`, `cfg_done` and `cfg_error` all 0; FSM in IDLE. Reset takes effect immediately regardless of the clock.
- `start` sampled at edge N: LOAD and `cfg_ready`=1 from edge N onward. The first word can transfer at edge N+1.
- With `cfg_valid` held high, WORDS+1 transfers occupy WORDS+1 consecutive edges. The commit, plus `cfg_done` or `cfg_error`, is visible right after the edge that takes the checksum word. At DW=16, `cfg_done` rises 178 edges after the start edge.
- `cfg_ready` drops in the same edge that accepts the checksum word. No extra words are accepted after it.
- Reset asserted mid-LOAD:
  - Shadow state, outputs, counter and XOR all cleared; state returns to IDLE.
  - A new `start` is required after release.
- Gaps in `cfg_valid` only stretch the load; there is no timeout.

## Test plan
- Reset: assert `rst_n`=0 mid-clock → all outputs 0 immediately. Release with `start`=0 → IDLE, `cfg_ready`=0.
- Pattern load at DW=16:
  - Stimulus: word 0 = 16'h0020, word 169 = 16'h0010, word 174 = 16'h4000, all other data words 0, checksum 16'h4030, `cfg_valid` held high.
  - Required: `brbselect`[5]=1, `leftioselect`[0]=1, `bottomioselect`[0]=1, all other bits 0; `cfg_done`=1 at start edge + 178.
- Bad checksum: repeat the pattern load with checksum 16'h4031 after a good all-zero load → `cfg_error`=1, `cfg_done`=0, all outputs stay 0.
- Throttled stream: `cfg_valid` toggling every cycle with the pattern image → same final outputs, `cfg_done` at start edge + 356. No word is duplicated or skipped.
- Reset mid-load: drop `rst_n` after 50 words of a load that follows a committed pattern → outputs cleared to 0 and IDLE. A subsequent full load then succeeds.
- `start` pulsed at word 100 of a load → ignored. The load completes normally with the image unchanged.
